// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration blocks.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} arb_state_t;

  localparam int DBIT_DEFAULT = 8;

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1 with wrap.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [PW-1:0] grant,
  output logic          valid
);

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        grant = PW'((int'(last) + i) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte producers.
// Optional sticky-grant lock input enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N          = 4,
  parameter int DBIT       = DBIT_DEFAULT,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic [N*DBIT-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    ack,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick
);

  localparam int PW = ptr_width(N);

  arb_state_t    state;
  logic [PW-1:0] last;
  logic [PW-1:0] pick;
  logic [PW-1:0] sel;
  logic          pick_valid;
  logic          hold;
  logic [7:0]    gap_cnt;

  uart_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (req),
    .last  (last),
    .grant (pick),
    .valid (pick_valid)
  );

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_pend;

  // Lock is sampled in the done cycle; when a gap follows, the decision is carried in lock_pend.
  always_comb begin
    hold = req[last] & ((|done) ? lock[last] : lock_pend);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_pend <= 1'b0;
    end else if (state == IDLE && (hold || pick_valid)) begin
      lock_pend <= 1'b0;
    end else if (|done) begin
      lock_pend <= lock[last] & req[last];
    end
  end
`else
  assign hold = 1'b0;
`endif

  assign sel = hold ? last : pick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= PW'(N - 1);
      gap_cnt  <= '0;
      ack      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      ack      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (hold || pick_valid) begin
            tx_din    <= req_data[int'(sel)*DBIT +: DBIT];
            ack[sel]  <= 1'b1;
            last      <= sel;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          tx_start <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (tx_done_tick) begin
            done[last] <= 1'b1;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, randomized traffic, gap/reset/lock corners.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req_g;
  logic [31:0] req_data, req_data_g;
  logic [3:0]  ack, done, ack_g, done_g;
  logic        busy, tx_start, busy_g, tx_start_g;
  logic [7:0]  tx_din, tx_din_g;
  logic        tick, tick_g;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  lock, lock_g;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(4), .DBIT(8), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .done(done), .busy(busy), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done_tick(tick)
  );

  uart_tx_arbiter #(.N(4), .DBIT(8), .GAP_CYCLES(5)) dut_g (
    .clk(clk), .reset_n(reset_n), .req(req_g), .req_data(req_data_g),
`ifdef UART_TX_ARB_LOCK_EN
    .lock(lock_g),
`endif
    .ack(ack_g), .done(done_g), .busy(busy_g), .tx_start(tx_start_g),
    .tx_din(tx_din_g), .tx_done_tick(tick_g)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] data [4];
  int m_last = 3;

  typedef struct {
    logic [3:0] r;
    int         g;
    bit         spur;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_data();
    return {data[3], data[2], data[1], data[0]};
  endfunction

  // Reference: nearest requester after the previous grant, walking the ring once.
  function automatic int model_pick(input logic [3:0] r);
    for (int i = 1; i <= 4; i++)
      if (r[(m_last + i) % 4]) return (m_last + i) % 4;
    return -1;
  endfunction

  // Starts with the DUT idle at edge+1; ends in the done cycle (DUT idle again).
  task automatic txn(input logic [3:0] r, input int exp_g, input int wait_cyc,
                     input bit toggle, input bit spur_load);
    logic [7:0] exp_d;
    req      = r;
    req_data = pack_data();
    exp_d    = data[exp_g];
    step();
    chk("ack", 32'(ack), 32'(1) << exp_g);
    chk("tx_din_at_ack", 32'(tx_din), 32'(exp_d));
    chk("start_early", 32'(tx_start), 0);
    chk("busy_load", 32'(busy), 1);
    if (spur_load) tick = 1'b1;
    step();
    tick = 1'b0;
    chk("tx_start", 32'(tx_start), 1);
    chk("ack_one_cycle", 32'(ack), 0);
    chk("done_spurious", 32'(done), 0);
    for (int w = 0; w < wait_cyc; w++) begin
      if (toggle) begin
        for (int j = 0; j < 4; j++) data[j] = 8'($urandom);
        req_data = pack_data();
      end
      step();
      chk("tx_din_hold", 32'(tx_din), 32'(exp_d));
      chk("start_one_cycle", 32'(tx_start), 0);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("done", 32'(done), 32'(1) << exp_g);
    chk("busy_after_done", 32'(busy), 0);
    m_last = exp_g;
  endtask

  initial begin
    int n;
    bit flag_done, flag_busy;
    logic [3:0] r;

    reset_n = 1'b0; req = '0; req_g = '0; req_data = '0; req_data_g = '0;
    tick = 1'b0; tick_g = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    lock = '0; lock_g = '0;
`endif
    data[0] = 8'h10; data[1] = 8'h21; data[2] = 8'h32; data[3] = 8'h43;

    tbl[0] = '{4'b0001, 0, 1'b0};
    tbl[1] = '{4'b1111, 1, 1'b0};
    tbl[2] = '{4'b1111, 2, 1'b1};
    tbl[3] = '{4'b1111, 3, 1'b0};
    tbl[4] = '{4'b1111, 0, 1'b0};
    tbl[5] = '{4'b1001, 3, 1'b0};
    tbl[6] = '{4'b1001, 0, 1'b0};
    tbl[7] = '{4'b1001, 3, 1'b1};
    tbl[8] = '{4'b0100, 2, 1'b0};
    tbl[9] = '{4'b0110, 1, 1'b0};

    step(); step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_din", 32'(tx_din), 0);
    chk("rst_busy_g", 32'(busy_g), 0);
    reset_n = 1'b1;
    step();

    // Single requester with 0xA5 first, then the rotation table.
    data[0] = 8'hA5;
    txn(4'b0001, 0, 2, 1'b0, 1'b0);
    data[0] = 8'h10; data[1] = 8'h21; data[2] = 8'h32; data[3] = 8'h43;
    for (int i = 0; i < 10; i++) txn(tbl[i].r, tbl[i].g, 2, 1'b0, tbl[i].spur);

    // Spurious tick while idle.
    req = '0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("idle_tick_done", 32'(done), 0);
    chk("idle_tick_busy", 32'(busy), 0);
    step();
    chk("idle_tick_done2", 32'(done), 0);
    chk("idle_no_ack", 32'(ack), 0);

    // Randomized traffic against the rotation model.
    for (int it = 0; it < 40; it++) begin
      r = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) data[j] = 8'($urandom);
      if (r == 4'b0) begin
        req = '0;
        step();
        chk("rand_idle_ack", 32'(ack), 0);
        chk("rand_idle_busy", 32'(busy), 0);
      end else begin
        txn(r, model_pick(r), $urandom_range(1, 4), 1'b1, 1'($urandom_range(0, 1)));
      end
    end

    // Reset mid-WAIT.
    req = 4'b0100;
    req_data = pack_data();
    step(); step(); step();
    reset_n = 1'b0;
    #2;
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_tx_din", 32'(tx_din), 0);
    req = '0;
    step();
    reset_n = 1'b1;
    m_last = 3;
    step();
    txn(4'b1111, 0, 1, 1'b0, 1'b0);

    // GAP_CYCLES=5: tick-to-next-start spacing with continuous requests.
    req_data_g = 32'h4433_2211;
    req_g = 4'b0011;
    n = 0;
    while (!tx_start_g && n < 10) begin step(); n++; end
    chk("gap_first_start", 32'(tx_start_g), 1);
    chk("gap_first_din", 32'(tx_din_g), 32'h11);
    step(); step();
    tick_g = 1'b1;
    step();
    tick_g = 1'b0;
    chk("gap_done", 32'(done_g), 1);
    chk("gap_busy", 32'(busy_g), 1);
    n = 1;
    flag_done = 1'b0;
    flag_busy = 1'b0;
    while (!tx_start_g && n < 20) begin
      tick_g = (n == 2);
      step();
      n++;
      if (done_g != 4'b0) flag_done = 1'b1;
      if (n <= 5 && !busy_g) flag_busy = 1'b1;
      if (n == 7) chk("gap_ack_second", 32'(ack_g), 32'b0010);
    end
    tick_g = 1'b0;
    chk("gap_spacing", 32'(n), 8);
    chk("gap_tick_ignored", 32'(flag_done), 0);
    chk("gap_busy_held", 32'(flag_busy), 0);
    chk("gap_second_din", 32'(tx_din_g), 32'h22);
    req_g = '0;

`ifdef UART_TX_ARB_LOCK_EN
    reset_n = 1'b0;
    req = '0;
    step();
    reset_n = 1'b1;
    m_last = 3;
    step();
    data[0] = 8'h10; data[1] = 8'h21;
    lock = 4'b0010;
    txn(4'b0011, 0, 1, 1'b0, 1'b0);
    txn(4'b0011, 1, 1, 1'b0, 1'b0);
    txn(4'b0011, 1, 1, 1'b0, 1'b0);
    txn(4'b0011, 1, 1, 1'b0, 1'b0);
    lock = 4'b0000;
    txn(4'b0011, 0, 1, 1'b0, 1'b0);
`endif

    req = '0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N byte-producing requesters using round-robin arbitration.
- Accepts one byte per grant, pulses the transmitter's start strobe, holds the data stable, and waits for the transmitter's done tick before the next grant.
- Sits between client blocks (command responder, debug logger, etc.) and the single uart_tx instance.

Parameters:
- N, 4, number of requesters (2..8).
- DBIT, 8, data bits per character; must match the transmitter.
- GAP_CYCLES, 0, idle clk cycles inserted after each tx_done_tick before the next grant (0..255).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  N  per-requester level request; byte valid while high
- req_data  input  N*DBIT  flattened bytes; requester i occupies bits [i*DBIT +: DBIT]
- ack  output  N  one-cycle pulse: requester's byte captured; requester may change data or drop req next cycle
- done  output  N  one-cycle pulse: requester's byte fully transmitted (stop bit complete)
- busy  output  1  high in any state other than IDLE
- tx_start  output  1  one-cycle start strobe to the transmitter
- tx_din  output  DBIT  byte to the transmitter
- tx_done_tick  input  1  transmitter completion pulse

Behaviour:
- Reset values: ack=0, done=0, busy=0, tx_start=0, tx_din=0, state=IDLE, gap counter=0, last-grant pointer=N-1 (so requester 0 has top priority first).
- States: IDLE, LOAD, WAIT, GAP. All outputs are registered.
- IDLE: if req != 0, select the first set bit scanning from last+1 upward with wrap (modulo N).
  - Capture req_data slice into tx_din, pulse ack[g], set last=g, go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD: tx_start=1 for exactly this one cycle; go to WAIT.
  - Latency: req seen in IDLE at cycle k gives ack at k+1 and tx_start at k+2.
- WAIT: hold tx_din; ignore req changes. On tx_done_tick: pulse done[g] next cycle.
  - If GAP_CYCLES == 0, go to IDLE; otherwise clear the counter and go to GAP.
- GAP: count 0..GAP_CYCLES-1, then go to IDLE. busy stays high.
- tx_din is stable from the ack cycle until the next capture. It is never changed while in LOAD or WAIT.
- tx_done_tick arriving in IDLE, LOAD or GAP is ignored; no done pulse is generated.
- A requester dropping req after ack has no effect on the transfer in flight. A requester dropping req before grant is simply not selected.
- A requester holding req continuously receives one grant per round-robin rotation; it is never granted twice in a row while another requester has req high.
- Simultaneous done and new requests: done pulses first, and arbitration occurs only in IDLE. Minimum spacing between tx_start pulses equals the transmitter frame time plus GAP_CYCLES + 3 cycles.
- Reset asserted mid-frame: immediate return to reset values; pending ack/done pulses are lost. The transmitter is reset by the same reset_n.
- Only one bit of ack, and only one bit of done, is ever set in any cycle.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- When defined:
  - Adds input lock (width N).
  - If lock[g] and req[g] are both high in the cycle that done[g] is pulsed, the next IDLE grant goes to g regardless of round-robin order (multi-byte message stays contiguous). The pointer stays at g.
  - Lock is sampled only then; dropping lock releases normal rotation.
- When undefined: no lock port; pure round-robin as above.

Decomposition:
- Shared package uart_pkg:
  - arb_state_t enum (IDLE, LOAD, WAIT, GAP);
  - localparam DBIT_DEFAULT=8;
  - function for pointer width ($clog2(N), minimum 1).
- One sub-module: uart_rr_pick.
  - Purely combinational: given req and last, returns grant index and valid.
  - Reusable by a future RX dispatch block.

Test Plan:
- Single requester: req=0001, data0=0xA5 -> ack[0] at k+1, tx_start one cycle at k+2 with tx_din=0xA5; done[0] one cycle after tx_done_tick; busy falls after that.
- All four requesting continuously with data 0x10/0x21/0x32/0x43 -> tx_din sequence 0x10,0x21,0x32,0x43,0x10; no requester granted twice consecutively.
- Pointer wrap: after grant to 3, req=1001 -> next grant 0; after grant to 0, req=1001 -> grant 3.
- Spurious tx_done_tick in IDLE and LOAD -> no done pulse, state unchanged; tx_din stays constant through WAIT while req_data toggles.
- GAP_CYCLES=5: measure tx_done_tick to next tx_start -> exactly 5+3 cycles with continuous req. Reset pulsed mid-WAIT -> all outputs 0 and next grant goes to requester 0.
- With UART_TX_ARB_LOCK_EN: req=0011, lock=0010, grant to 1 -> requester 1 receives three consecutive grants until lock drops, then requester 0 is granted.
